// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF/MEM requester ports, the external memory port and the
// stall requests shared between the arbiter and its environment.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned BW = DW / 8;

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_done;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic [DW-1:0] d_rdata;
  logic          d_done;

  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_rdata;
  logic          m_ready;

  logic          stall_if;
  logic          stall_mem;

  // Environment side: pipeline requesters plus the memory responder.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ready,
    input  i_rdata, i_done, d_rdata, d_done,
    input  m_req, m_we, m_addr, m_wdata, m_be, stall_if, stall_mem
  );

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ready,
    output i_rdata, i_done, d_rdata, d_done,
    output m_req, m_we, m_addr, m_wdata, m_be, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and the MEM
// stage: one transfer at a time, round-robin on ties, per-stage stalls.
module mem_port_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned BW = DW / 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] IBUSY = 2'd1;
  localparam logic [1:0] DBUSY = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_d;
  logic          last_d;
  logic          grant_i;
  logic          grant_d;
  logic          finish;
  logic          i_elig;
  logic          d_elig;

  logic          m_req_q;
  logic          m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic [BW-1:0] m_be_q;
  logic          i_done_q;
  logic          d_done_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;

  // A requester is masked during its own done cycle so a held req is not regranted.
  assign i_elig = bus.i_req & ~i_done_q;
  assign d_elig = bus.d_req & ~d_done_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state: grant in IDLE (tie goes to whoever lost last), finish on m_ready.
  always_comb begin
    state_d = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (d_elig && (!i_elig || !last_d)) begin
          grant_d = 1'b1;
          state_d = DBUSY;
        end else if (i_elig) begin
          grant_i = 1'b1;
          state_d = IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (bus.m_ready) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the granted request, capture read data and pulse done on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_d    <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      if (grant_i) begin
        m_req_q   <= 1'b1;
        m_we_q    <= 1'b0;
        m_addr_q  <= bus.i_addr;
        m_wdata_q <= '0;
        m_be_q    <= {BW{1'b1}};
        last_d    <= 1'b0;
      end else if (grant_d) begin
        m_req_q   <= 1'b1;
        m_we_q    <= bus.d_we;
        m_addr_q  <= bus.d_addr;
        m_wdata_q <= bus.d_wdata;
        m_be_q    <= bus.d_we ? bus.d_be : {BW{1'b1}};
        last_d    <= 1'b1;
      end
      if (finish) begin
        m_req_q <= 1'b0;
        if (state == IBUSY) begin
          i_rdata_q <= bus.m_rdata;
          i_done_q  <= 1'b1;
        end else begin
          d_rdata_q <= bus.m_rdata;
          d_done_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.m_req     = m_req_q;
  assign bus.m_we      = m_we_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_be      = m_be_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall_if  = bus.i_req & ~i_done_q;
  assign bus.stall_mem = bus.d_req & ~d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// requester/memory traffic checked against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } xfer_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the port, the latched transfer, done/rdata.
  int          own;      // 0 none, 1 fetch, 2 data
  bit          last_d;
  xfer_t       cur;
  bit          e_idone, e_ddone;
  logic [31:0] e_irdata, e_drdata;

  // Inputs applied during the previous cycle (seen by the next clock edge).
  bit          p_reset, p_ireq, p_dreq, p_dwe, p_mready;
  logic [31:0] p_iaddr, p_daddr, p_dwdata, p_mrdata;
  logic [3:0]  p_dbe;

  // Random requester state.
  bit          ri_rel, rd_rel, r_ireq, r_dreq, r_dwe, r_mready;
  logic [31:0] r_iaddr, r_daddr, r_dwdata, r_mrdata;
  logic [3:0]  r_dbe;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    own      = 0;
    last_d   = 1'b0;
    cur      = '0;
    e_idone  = 1'b0;
    e_ddone  = 1'b0;
    e_irdata = '0;
    e_drdata = '0;
  endfunction

  // One clock edge worth of transaction-level behaviour.
  function automatic void model_step();
    bit ie, de;
    if (p_reset) begin
      model_reset();
      return;
    end
    ie = p_ireq && !e_idone;
    de = p_dreq && !e_ddone;
    e_idone = 1'b0;
    e_ddone = 1'b0;
    if (own != 0) begin
      if (p_mready) begin
        if (own == 1) begin e_irdata = p_mrdata; e_idone = 1'b1; end
        else          begin e_drdata = p_mrdata; e_ddone = 1'b1; end
        own = 0;
      end
    end else if (ie || de) begin
      own = (de && (!ie || !last_d)) ? 2 : 1;
      if (own == 1) begin
        cur.we = 1'b0; cur.addr = p_iaddr; cur.wdata = '0; cur.be = 4'hF;
      end else begin
        cur.we = p_dwe; cur.addr = p_daddr; cur.wdata = p_dwdata;
        cur.be = p_dwe ? p_dbe : 4'hF;
      end
      last_d = (own == 2);
    end
  endfunction

  task automatic check_outputs(input bit ireq, input bit dreq);
    chk("m_req", 32'(bus.m_req), 32'(own != 0));
    if (own != 0) begin
      chk("m_addr", bus.m_addr, cur.addr);
      chk("m_we", 32'(bus.m_we), 32'(cur.we));
      chk("m_be", 32'(bus.m_be), 32'(cur.be));
      if (cur.we) chk("m_wdata", bus.m_wdata, cur.wdata);
    end
    chk("i_done", 32'(bus.i_done), 32'(e_idone));
    chk("d_done", 32'(bus.d_done), 32'(e_ddone));
    chk("i_rdata", bus.i_rdata, e_irdata);
    chk("d_rdata", bus.d_rdata, e_drdata);
    chk("stall_if", 32'(bus.stall_if), 32'(ireq && !e_idone));
    chk("stall_mem", 32'(bus.stall_mem), 32'(dreq && !e_ddone));
    chk("one_done", 32'(bus.i_done & bus.d_done), 32'd0);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    model_step();
  endtask

  task automatic drive_check(input bit ireq, input logic [31:0] iaddr,
                             input bit dreq, input bit dwe, input logic [31:0] daddr,
                             input logic [31:0] dwdata, input logic [3:0] dbe,
                             input bit mready, input logic [31:0] mrdata);
    reset = 1'b0;
    bus.i_req = ireq;  bus.i_addr = iaddr;
    bus.d_req = dreq;  bus.d_we = dwe; bus.d_addr = daddr;
    bus.d_wdata = dwdata; bus.d_be = dbe;
    bus.m_ready = mready; bus.m_rdata = mrdata;
    p_reset = 1'b0; p_ireq = ireq; p_iaddr = iaddr;
    p_dreq = dreq; p_dwe = dwe; p_daddr = daddr; p_dwdata = dwdata; p_dbe = dbe;
    p_mready = mready; p_mrdata = mrdata;
    #1 check_outputs(ireq, dreq);
  endtask

  task automatic cycle(input bit ireq, input logic [31:0] iaddr,
                       input bit dreq, input bit dwe, input logic [31:0] daddr,
                       input logic [31:0] dwdata, input logic [3:0] dbe,
                       input bit mready, input logic [31:0] mrdata);
    next_cycle();
    drive_check(ireq, iaddr, dreq, dwe, daddr, dwdata, dbe, mready, mrdata);
  endtask

  // Reset asserted mid-cycle: outputs must clear without waiting for a clock.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.m_ready = 1'b0; bus.m_rdata = '0;
    model_reset();
    p_reset = 1'b1; p_ireq = 1'b0; p_dreq = 1'b0; p_mready = 1'b0;
    #1;
    chk("rst_m_req", 32'(bus.m_req), 32'd0);
    chk("rst_m_addr", bus.m_addr, 32'd0);
    chk("rst_m_be", 32'(bus.m_be), 32'd0);
    chk("rst_i_done", 32'(bus.i_done), 32'd0);
    chk("rst_d_done", 32'(bus.d_done), 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
  endtask

  initial begin
    apply_reset();

    // Single fetch against zero-wait memory.
    cycle(1, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0);
    chk("fetch_stall0", 32'(bus.stall_if), 32'd1);
    cycle(1, 32'h0040_0000, 0, 0, 0, 0, 0, 1, 32'h2008_0005);
    chk("fetch_addr", bus.m_addr, 32'h0040_0000);
    chk("fetch_be", 32'(bus.m_be), 32'hF);
    chk("fetch_stall1", 32'(bus.stall_if), 32'd1);
    cycle(1, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0);
    chk("fetch_done", 32'(bus.i_done), 32'd1);
    chk("fetch_rdata", bus.i_rdata, 32'h2008_0005);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Store with three wait states, then req held through done and regranted.
    cycle(0, 0, 1, 1, 32'h1001_0004, 32'hDEAD_BEEF, 4'b0011, 0, 0);
    for (int k = 0; k < 3; k++)
      cycle(0, 0, 1, 1, 32'h1001_0004, 32'hDEAD_BEEF, 4'b0011, 0, 0);
    cycle(0, 0, 1, 1, 32'h1001_0004, 32'hDEAD_BEEF, 4'b0011, 1, 32'h5555_AAAA);
    chk("store_be", 32'(bus.m_be), 32'h3);
    cycle(0, 0, 1, 1, 32'h1001_0004, 32'hDEAD_BEEF, 4'b0011, 0, 0);
    chk("store_done", 32'(bus.d_done), 32'd1);
    chk("held_no_regrant", 32'(bus.m_req), 32'd0);
    cycle(0, 0, 1, 0, 32'h1001_0008, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 32'h1001_0008, 0, 0, 1, 32'h0BAD_F00D);
    chk("regrant_d", bus.m_addr, 32'h1001_0008);
    cycle(0, 0, 1, 0, 32'h1001_0008, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Spurious ready while idle; fetch address changes mid-transfer.
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_1111);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h2222_2222);
    cycle(1, 32'h0040_0010, 0, 0, 0, 0, 0, 1, 32'h3333_3333);
    cycle(1, 32'h0040_0020, 0, 0, 0, 0, 0, 0, 0);
    chk("addr_hold", bus.m_addr, 32'h0040_0010);
    cycle(1, 32'h0040_0030, 0, 0, 0, 0, 0, 1, 32'h4444_4444);
    cycle(1, 32'h0040_0030, 0, 0, 0, 0, 0, 0, 0);
    chk("addr_hold_rdata", bus.i_rdata, 32'h4444_4444);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset during a data transfer, then a tie from reset goes D, I, D, I.
    cycle(0, 0, 1, 1, 32'h1000_0000, 32'h1234_5678, 4'hC, 0, 0);
    cycle(0, 0, 1, 1, 32'h1000_0000, 32'h1234_5678, 4'hC, 0, 0);
    cycle(0, 0, 1, 1, 32'h1000_0000, 32'h1234_5678, 4'hC, 0, 0);
    apply_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h7777_7777);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 32'h0040_0100, 1, 0, 32'h1001_0000, 0, 0, 1, 32'hA000_0001);
    cycle(1, 32'h0040_0100, 1, 0, 32'h1001_0000, 0, 0, 1, 32'hA000_0002);
    chk("tie_first_d", bus.m_addr, 32'h1001_0000);
    for (int k = 0; k < 8; k++)
      cycle(1, 32'h0040_0100, 1, 0, 32'h1001_0000, 0, 0, 1, $urandom);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'hB000_0000);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'hB000_0001);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic from a clean reset.
    apply_reset();
    ri_rel = 1'b0; rd_rel = 1'b0; r_ireq = 1'b0; r_dreq = 1'b0; r_dwe = 1'b0;
    r_iaddr = '0; r_daddr = '0; r_dwdata = '0; r_dbe = '0;
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      if (e_idone) ri_rel = 1'b1;
      else if (ri_rel) begin
        ri_rel = 1'b0;
        r_ireq = 1'($urandom_range(0, 1));
        r_iaddr = $urandom;
      end else if (!r_ireq) begin
        if ($urandom_range(0, 3) == 0) begin r_ireq = 1'b1; r_iaddr = $urandom; end
      end else if (own == 1 && $urandom_range(0, 7) == 0) r_iaddr = $urandom;

      if (e_ddone) rd_rel = 1'b1;
      else if (rd_rel || !r_dreq) begin
        if (rd_rel) r_dreq = 1'($urandom_range(0, 1));
        else        r_dreq = ($urandom_range(0, 3) == 0);
        rd_rel = 1'b0;
        r_dwe = 1'($urandom_range(0, 1));
        r_daddr = $urandom;
        r_dwdata = $urandom;
        r_dbe = 4'($urandom_range(0, 15));
      end else if (own == 2 && $urandom_range(0, 7) == 0) r_daddr = $urandom;

      r_mready = ($urandom_range(0, 9) < 4);
      r_mrdata = $urandom;
      drive_check(r_ireq, r_iaddr, r_dreq, r_dwe, r_daddr, r_dwdata, r_dbe,
                  r_mready, r_mrdata);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
